// File: rtl/hgcal_ae_pkg.sv
// Shared types and constants for the HGCAL autoencoder front end.
package hgcal_ae_pkg;

  // Quantized width per cell; fixed for this revision.
  localparam int unsigned OUT_BW = 2;

  // Default quantizer thresholds (10-bit raw charge).
  localparam logic [9:0] DefT0 = 10'd16;
  localparam logic [9:0] DefT1 = 10'd64;
  localparam logic [9:0] DefT2 = 10'd256;

  // Frame assembly state.
  typedef enum logic [1:0] {
    StFill,
    StFull,
    StDiscard,
    StFullDrain
  } state_e;

  // Width of a packed frame of n_in quantized cells.
  function automatic int unsigned frame_w(input int unsigned n_in);
    return n_in * OUT_BW;
  endfunction

endpackage

// File: rtl/hgcal_cell_quantizer.sv
// Combinational per-cell quantizer: raw unsigned charge to a 2-bit code
// using three ascending thresholds.
module hgcal_cell_quantizer
  import hgcal_ae_pkg::*;
#(
  parameter int unsigned     IN_W = 10,
  parameter logic [IN_W-1:0] T0   = IN_W'(DefT0),
  parameter logic [IN_W-1:0] T1   = IN_W'(DefT1),
  parameter logic [IN_W-1:0] T2   = IN_W'(DefT2)
) (
  input  logic [IN_W-1:0]   x,
  output logic [OUT_BW-1:0] q
);

  // Highest threshold wins; all compares are unsigned.
  always_comb begin
    q = 2'd0;
    if (x >= T2) begin
      q = 2'd3;
    end else if (x >= T1) begin
      q = 2'd2;
    end else if (x >= T0) begin
      q = 2'd1;
    end
  end

endmodule

// File: rtl/hgcal_input_quantizer.sv
// Input stage of the HGCAL autoencoder: quantizes a stream of raw cell
// charges, packs N_IN cells into one held frame and flags bad frame lengths.
module hgcal_input_quantizer
  import hgcal_ae_pkg::*;
#(
  parameter int unsigned     N_IN  = 48,
  parameter int unsigned     IN_W  = 10,
  parameter logic [IN_W-1:0] T0    = IN_W'(DefT0),
  parameter logic [IN_W-1:0] T1    = IN_W'(DefT1),
  parameter logic [IN_W-1:0] T2    = IN_W'(DefT2),
  parameter int unsigned     CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [IN_W-1:0]            s_data,
  input  logic                       s_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [frame_w(N_IN)-1:0]   m_data,
  output logic                       err_short,
  output logic                       err_long,
  output logic [CNT_W-1:0]           frame_cnt
);

  localparam int unsigned     FrameW  = frame_w(N_IN);
  localparam int unsigned     IdxW    = $clog2(N_IN);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_IN - 1);

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [FrameW-1:0]   asm_q, asm_d, asm_wr;
  logic [FrameW-1:0]   m_data_q, m_data_d;
  logic                pending_q, pending_d;
  logic                err_short_q, err_short_d;
  logic                err_long_q, err_long_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [OUT_BW-1:0]   q_cell;
  logic                beat;
  logic                hs;

  hgcal_cell_quantizer #(
    .IN_W (IN_W),
    .T0   (T0),
    .T1   (T1),
    .T2   (T2)
  ) u_cell_quantizer (
    .x (s_data),
    .q (q_cell)
  );

  // Stream handshakes are a pure function of state; s_ready is held low in reset.
  always_comb begin
    s_ready = 1'b0;
    m_valid = 1'b0;
    unique case (state_q)
      StFill:      s_ready = rst;
      StFull:      m_valid = 1'b1;
      StDiscard: begin
        s_ready = rst;
        m_valid = 1'b1;
      end
      StFullDrain: s_ready = rst;
      default:     s_ready = 1'b0;
    endcase
  end

  assign beat = s_valid & s_ready;
  assign hs   = m_valid & m_ready;

  // Assembly register with the current beat's code dropped into slot idx.
  always_comb begin
    asm_wr = asm_q;
    asm_wr[idx_q * OUT_BW +: OUT_BW] = q_cell;
  end

  // Next-state: frame assembly, hold and overrun discard.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    asm_d       = asm_q;
    m_data_d    = m_data_q;
    pending_d   = pending_q;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    cnt_d       = cnt_q + CNT_W'(hs);

    unique case (state_q)
      StFill: begin
        if (beat) begin
          asm_d = asm_wr;
          if (idx_q == LastIdx) begin
            m_data_d = asm_wr;
            idx_d    = '0;
            if (s_last) begin
              state_d = StFull;
            end else begin
              // Overlong frame: deliver the first N_IN cells, drop the rest.
              state_d    = StDiscard;
              pending_d  = 1'b1;
              err_long_d = 1'b1;
            end
          end else if (s_last) begin
            // Short frame: dropped; stale slots get overwritten by the next one.
            idx_d       = '0;
            err_short_d = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      StFull: begin
        if (hs) begin
          state_d = StFill;
        end
      end

      StDiscard: begin
        if (beat && s_last) begin
          pending_d = 1'b0;
        end
        if (hs) begin
          if (!pending_q || (beat && s_last)) begin
            state_d   = StFill;
            pending_d = 1'b0;
          end else begin
            state_d = StFullDrain;
          end
        end
      end

      StFullDrain: begin
        if (beat && s_last) begin
          state_d   = StFill;
          pending_d = 1'b0;
        end
      end

      default: state_d = StFill;
    endcase
  end

  // State and datapath registers; reset discards partial and held frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StFill;
      idx_q       <= '0;
      asm_q       <= '0;
      m_data_q    <= '0;
      pending_q   <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      asm_q       <= asm_d;
      m_data_q    <= m_data_d;
      pending_q   <= pending_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      cnt_q       <= cnt_d;
    end
  end

  assign m_data    = m_data_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign frame_cnt = cnt_q;

`ifndef SYNTHESIS
  // A presented frame stays valid and stable until it is taken.
  m_valid_hold_a: assert property (@(posedge clk) disable iff (!rst)
    (m_valid && !m_ready) |=> (m_valid && $stable(m_data)));
`endif

endmodule
